// File: rtl/stack_frame_pkg.sv
// Shared types and width helpers for the frame stack controller.
package stack_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUSH    = 2'd1,
        ST_POP     = 2'd2,
        ST_CONFIRM = 2'd3
    } state_e;

    // Width of a counter holding 0..depth frames
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned addr_w(input int unsigned depth, input int unsigned fields);
        return (depth * fields > 1) ? $clog2(depth * fields) : 1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned fields);
        return (fields > 1) ? $clog2(fields) : 1;
    endfunction

endpackage

// File: rtl/stack_frame_ram.sv
// Frame storage: flat register array, synchronous write, asynchronous read, no reset.
module stack_frame_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WORDS  = 48,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_frame_ctrl.sv
// Call-frame stack controller: pushes/pops FIELDS-word frames one field per cycle.
// Optional STACK_PEEK_EN adds peek_req, which replays the top frame without popping it.
module stack_frame_ctrl
    import stack_frame_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned FIELDS = 3,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned LVL_W  = lvl_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_req,
    input  logic                     pop_req,
    input  logic [FIELDS*DATA_W-1:0] push_data,
`ifdef STACK_PEEK_EN
    input  logic                     peek_req,
`endif
    output logic                     ready,
    output logic [FIELDS-1:0]        field_en,
    output logic [DATA_W-1:0]        pop_field,
    output logic [FIELDS*DATA_W-1:0] pop_data,
    output logic                     pop_valid,
    output logic                     full,
    output logic                     empty,
    output logic [LVL_W-1:0]         level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned ADDR_W  = addr_w(DEPTH, FIELDS);
    localparam int unsigned IDX_W   = idx_w(FIELDS);
    localparam int unsigned FRAME_W = FIELDS * DATA_W;
    localparam int unsigned WORDS   = DEPTH * FIELDS;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FIELDS - 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEPTH);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic [FRAME_W-1:0] asm_q, asm_d;
    logic [FRAME_W-1:0] pop_data_q, pop_data_d;
    logic               pop_valid_q, pop_valid_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
`ifdef STACK_PEEK_EN
    logic               peek_q, peek_d;
`endif

    logic               mem_we;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  wr_data;
    logic [DATA_W-1:0]  rd_data;

    // Push writes above the top frame; pop reads the top frame (level-1).
    always_comb begin
        wr_addr = ADDR_W'(int'(level_q) * int'(FIELDS) + int'(idx_q));
        rd_addr = ADDR_W'((int'(level_q) - 1) * int'(FIELDS) + int'(idx_q));
        wr_data = hold_q[int'(idx_q) * int'(DATA_W) +: DATA_W];
        mem_we  = (state_q == ST_PUSH);
    end

    stack_frame_ram #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        level_d     = level_q;
        hold_d      = hold_q;
        asm_d       = asm_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
`ifdef STACK_PEEK_EN
        peek_d      = peek_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (pop_req) begin
                    if (empty_q) begin
                        underflow_d = 1'b1;
                    end else begin
                        state_d = ST_POP;
                        idx_d   = IDX_LAST;
`ifdef STACK_PEEK_EN
                        peek_d  = 1'b0;
`endif
                    end
                end else if (push_req) begin
                    if (full_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        hold_d  = push_data;
                        state_d = ST_PUSH;
                        idx_d   = '0;
                    end
                end
`ifdef STACK_PEEK_EN
                else if (peek_req) begin
                    if (empty_q) begin
                        underflow_d = 1'b1;
                    end else begin
                        state_d = ST_POP;
                        idx_d   = IDX_LAST;
                        peek_d  = 1'b1;
                    end
                end
`endif
            end

            ST_PUSH: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_CONFIRM;
                    idx_d   = '0;
                    level_d = level_q + LVL_W'(1);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_POP: begin
                // Assemble in a shadow so pop_data stays stable until the frame is complete
                asm_d[int'(idx_q) * int'(DATA_W) +: DATA_W] = rd_data;
                if (idx_q == '0) begin
                    state_d     = ST_CONFIRM;
                    pop_data_d  = asm_d;
                    pop_valid_d = 1'b1;
`ifdef STACK_PEEK_EN
                    if (!peek_q) begin
                        level_d = level_q - LVL_W'(1);
                    end
`else
                    level_d = level_q - LVL_W'(1);
`endif
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end

            ST_CONFIRM: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        full_d  = (level_d == LVL_MAX);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            hold_q      <= '0;
            asm_q       <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef STACK_PEEK_EN
            peek_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            hold_q      <= hold_d;
            asm_q       <= asm_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef STACK_PEEK_EN
            peek_q      <= peek_d;
`endif
        end
    end

    // Strobes decode directly from the state/index registers
    assign ready     = (state_q == ST_IDLE);
    assign field_en  = (state_q == ST_POP) ? (FIELDS'(1) << idx_q) : '0;
    assign pop_field = (state_q == ST_POP) ? rd_data : '0;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Scoreboard bench for stack_frame_ctrl (DATA_W=8, FIELDS=3, DEPTH=4); peek checks under STACK_PEEK_EN.
module tb_stack_frame_ctrl;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned FIELDS  = 3;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned FRAME_W = FIELDS * DATA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               push_req;
    logic               pop_req;
    logic [FRAME_W-1:0] push_data;
`ifdef STACK_PEEK_EN
    logic               peek_req;
`endif
    logic               ready;
    logic [FIELDS-1:0]  field_en;
    logic [DATA_W-1:0]  pop_field;
    logic [FRAME_W-1:0] pop_data;
    logic               pop_valid;
    logic               full;
    logic               empty;
    logic [LVL_W-1:0]   level;
    logic               overflow;
    logic               underflow;

    stack_frame_ctrl #(
        .DATA_W (DATA_W),
        .FIELDS (FIELDS),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_req  (push_req),
        .pop_req   (pop_req),
        .push_data (push_data),
`ifdef STACK_PEEK_EN
        .peek_req  (peek_req),
`endif
        .ready     (ready),
        .field_en  (field_en),
        .pop_field (pop_field),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [FRAME_W-1:0] model_stk [DEPTH];
    int                 model_lvl = 0;
    logic [FRAME_W-1:0] exp_q [$];

    task automatic wait_ready();
        for (int c = 0; c < 20 && ready !== 1'b1; c++) @(negedge clk);
        if (ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL ready_timeout: ready=%b want 1", ready);
        end
    endtask

    task automatic check_status(input string tag);
        vectors++;
        if (level !== LVL_W'(model_lvl) || empty !== (model_lvl == 0) || full !== (model_lvl == DEPTH)) begin
            miscompares++;
            $display("FAIL %s_status: level=%0d empty=%b full=%b want level=%0d empty=%b full=%b",
                     tag, level, empty, full, model_lvl, model_lvl == 0, model_lvl == DEPTH);
        end
    endtask

    task automatic do_push(input logic [FRAME_W-1:0] f);
        wait_ready();
        push_req = 1'b1; push_data = f;
        @(negedge clk);
        push_req = 1'b0;
        if (model_lvl == DEPTH) begin
            vectors++;
            if (overflow !== 1'b1 || ready !== 1'b1) begin
                miscompares++;
                $display("FAIL overflow_pulse: overflow=%b ready=%b want 1 1", overflow, ready);
            end
            check_status("overflow");
            @(negedge clk);
            vectors++;
            if (overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL overflow_clear: overflow=%b want 0", overflow);
            end
            return;
        end
        for (int i = 0; i < FIELDS + 1; i++) begin
            vectors++;
            if (ready !== 1'b0 || field_en !== '0) begin
                miscompares++;
                $display("FAIL push_busy[%0d]: ready=%b field_en=%b want 0 000", i, ready, field_en);
            end
            @(negedge clk);
        end
        model_stk[model_lvl] = f;
        model_lvl++;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL push_done_ready: ready=%b want 1", ready);
        end
        check_status("push");
    endtask

    task automatic do_pop(input bit also_push, input bit is_peek);
        logic [FRAME_W-1:0] exp;
        logic [FRAME_W-1:0] got;
        logic [FIELDS-1:0]  exp_en;
        wait_ready();
        pop_req   = !is_peek;
        push_req  = also_push;
        push_data = 24'hEEDDCC;
`ifdef STACK_PEEK_EN
        peek_req  = is_peek;
`endif
        @(negedge clk);
        pop_req = 1'b0; push_req = 1'b0;
`ifdef STACK_PEEK_EN
        peek_req = 1'b0;
`endif
        if (model_lvl == 0) begin
            vectors++;
            if (underflow !== 1'b1 || ready !== 1'b1 || level !== '0) begin
                miscompares++;
                $display("FAIL underflow_pulse: underflow=%b ready=%b level=%0d want 1 1 0", underflow, ready, level);
            end
            @(negedge clk);
            vectors++;
            if (underflow !== 1'b0) begin
                miscompares++;
                $display("FAIL underflow_clear: underflow=%b want 0", underflow);
            end
            return;
        end
        exp = model_stk[model_lvl-1];
        exp_q.push_back(exp);
        if (!is_peek) model_lvl--;
        for (int k = FIELDS - 1; k >= 0; k--) begin
            exp_en = FIELDS'(1) << k;
            vectors++;
            if (field_en !== exp_en || pop_field !== exp[k*DATA_W +: DATA_W] || pop_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL pop_strobe[%0d]: field_en=%b pop_field=%h pop_valid=%b want %b %h 0",
                         k, field_en, pop_field, pop_valid, exp_en, exp[k*DATA_W +: DATA_W]);
            end
            @(negedge clk);
        end
        for (int c = 0; c < 4 && pop_valid !== 1'b1; c++) @(negedge clk);
        exp = exp_q.pop_front();
        got = pop_data;
        vectors++;
        if (pop_valid !== 1'b1 || got !== exp) begin
            miscompares++;
            $display("FAIL pop_frame: pop_valid=%b pop_data=%h want 1 %h", pop_valid, got, exp);
        end
        check_status(is_peek ? "peek" : "pop");
        @(negedge clk);
        vectors++;
        if (pop_valid !== 1'b0 || ready !== 1'b1 || pop_data !== exp) begin
            miscompares++;
            $display("FAIL pop_after: pop_valid=%b ready=%b pop_data=%h want 0 1 %h", pop_valid, ready, pop_data, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push_req = 1'b0; pop_req = 1'b0; push_data = '0;
`ifdef STACK_PEEK_EN
        peek_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || level !== '0 || field_en !== '0 ||
            pop_field !== '0 || pop_data !== '0 || pop_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b empty=%b full=%b level=%0d field_en=%b pop_field=%h pop_data=%h pv=%b ov=%b un=%b",
                     ready, empty, full, level, field_en, pop_field, pop_data, pop_valid, overflow, underflow);
        end
    endtask

    task automatic test_underflow();
        do_pop(1'b0, 1'b0);
        check_status("underflow");
    endtask

    task automatic test_single();
        do_push(24'h030201);
        do_pop(1'b0, 1'b0);
    endtask

    task automatic test_fill();
        do_push(24'h112233);
        do_push(24'h445566);
        do_push(24'h778899);
        do_push(24'hAABBCC);
        do_push(24'hDDEEFF);
        for (int i = 0; i < DEPTH; i++) do_pop(1'b0, 1'b0);
    endtask

    task automatic test_both();
        do_push(24'h102030);
        do_push(24'h405060);
        do_pop(1'b1, 1'b0);
        do_pop(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_push(24'h5A5A5A);
        wait_ready();
        push_req = 1'b1; push_data = 24'h123456;
        @(negedge clk);
        push_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_lvl = 0;
        exp_q.delete();
        vectors++;
        if (ready !== 1'b1 || level !== '0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: ready=%b level=%0d empty=%b want 1 0 1", ready, level, empty);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_pop(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) do_push(FRAME_W'($urandom));
            else do_pop(1'b0, 1'b0);
        end
        while (model_lvl > 0) do_pop(1'b0, 1'b0);
        check_status("drain");
    endtask

`ifdef STACK_PEEK_EN
    task automatic test_peek();
        do_push(24'h0A0B0C);
        do_pop(1'b0, 1'b1);
        do_pop(1'b0, 1'b0);
        do_pop(1'b0, 1'b1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_underflow();
        test_single();
        test_fill();
        test_both();
        test_reset_mid();
        test_back_to_back();
`ifdef STACK_PEEK_EN
        test_peek();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
